// File: rtl/ht_dn_pkg.sv
// ht_dn_pkg: shared types and constants for the ioctl download bridge.
//   dn_state_t   : bridge FSM states (IDLE, LOAD, DRAIN, DONE)
//   ROM_INDEX    : ioctl_index value that selects the ROM image
//   CAS_BASE_DEF : default base address for cassette images
//   dn_entry_t   : one FIFO entry, full write address plus data byte
package ht_dn_pkg;

    localparam int unsigned DN_ADDR_W = 25;
    localparam logic [7:0] ROM_INDEX = 8'd0;
    localparam logic [DN_ADDR_W-1:0] CAS_BASE_DEF = 25'h0010000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dn_state_t;

    typedef struct packed {
        logic [DN_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } dn_entry_t;

    localparam int unsigned DN_ENTRY_W = $bits(dn_entry_t);

endpackage

// File: rtl/ht_dn_bridge_if.sv
// ht_dn_bridge_if: download-side and memory-side signals of the bridge.
//   ioctl_download/wr/addr/data/index : HPS download port (into the bridge)
//   mem_req/addr/data, mem_ack        : core SDRAM write port
// Modports: slave = bridge view, master = environment (HPS + memory) view.
//
// Handshakes:
//   ioctl_wr is a one-cycle strobe with no back-pressure; a byte that finds
//   no room is lost. mem_req rises with mem_addr/mem_data valid and holds
//   them stable until mem_ack is sampled high on a rising edge of clk_sys;
//   mem_req then falls on the next cycle. mem_ack while mem_req=0 has no
//   effect.
interface ht_dn_bridge_if
    import ht_dn_pkg::*;
#(
    parameter int unsigned ADDR_W = DN_ADDR_W
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [13:0]       ioctl_addr;
    logic [7:0]        ioctl_data;
    logic [7:0]        ioctl_index;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ack;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ioctl_index,
        input  mem_ack,
        output mem_req, mem_addr, mem_data
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ioctl_index,
        output mem_ack,
        input  mem_req, mem_addr, mem_data
    );
endinterface

// File: rtl/ht_dn_fifo.sv
// ht_dn_fifo: synchronous FIFO with asynchronous active-high reset.
//   clk_sys, reset : clock / async reset (flushes the FIFO)
//   push, wdata    : write one entry (ignored when full unless popping)
//   pop, rdata     : rdata shows the head; pop removes it (ignored when empty)
//   full, empty    : occupancy flags
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ht_dn_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 33
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ht_dn_bridge.sv
// ht_dn_bridge: HPS ioctl download -> ht1080z memory write bridge.
//   clk_sys, reset : clock / asynchronous active-high reset
//   bus            : ht_dn_bridge_if.slave (ioctl download in, mem req/ack out)
//   dn_busy        : download active or writes still pending
//   rom_reset      : CPU reset request while a ROM image loads
//   cas_len        : highest cassette offset written + 1
//   cas_ready      : cassette image fully written to memory
//   overflow       : sticky, a byte was lost to a full FIFO
//   dbg_state      : current FSM state
//   dn_sum         : (only with HT_DN_CHECKSUM_EN) mod-256 sum of accepted bytes
// Optional feature macro: HT_DN_CHECKSUM_EN.
module ht_dn_bridge
    import ht_dn_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter int unsigned       ADDR_W     = DN_ADDR_W,
    parameter logic [ADDR_W-1:0] CAS_BASE   = CAS_BASE_DEF
) (
    input  logic          clk_sys,
    input  logic          reset,
    ht_dn_bridge_if.slave bus,
    output logic          dn_busy,
    output logic          rom_reset,
    output logic [14:0]   cas_len,
    output logic          cas_ready,
    output logic          overflow,
    output dn_state_t     dbg_state
`ifdef HT_DN_CHECKSUM_EN
    ,
    output logic [7:0]    dn_sum
`endif
);

    dn_state_t         state_q, state_d;
    logic              dl_q;
    logic              dl_rise, dl_fall;
    logic              start;
    logic [7:0]        idx_q;
    logic              mem_req_q;
    dn_entry_t         iss_q;
    logic              fifo_full, fifo_empty;
    logic [DN_ENTRY_W-1:0] fifo_rdata;
    logic              push_req, push_ok, pop;
    logic [ADDR_W-1:0] push_addr;
    dn_entry_t         push_entry;
    logic [14:0]       new_len;

    assign dl_rise = bus.ioctl_download && !dl_q;
    assign dl_fall = !bus.ioctl_download && dl_q;

    // Each entry carries its final address, so a restart while older
    // entries drain cannot re-target them.
    assign push_addr  = ADDR_W'(bus.ioctl_addr) + ((idx_q == ROM_INDEX) ? '0 : CAS_BASE);
    assign push_entry = '{addr: push_addr, data: bus.ioctl_data};
    assign new_len    = {1'b0, bus.ioctl_addr} + 15'd1;

    assign push_req = (state_q == LOAD) && bus.ioctl_wr;
    assign pop      = !mem_req_q && !fifo_empty;
    assign push_ok  = push_req && (!fifo_full || pop);

    ht_dn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DN_ENTRY_W)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (push_ok),
        .wdata   (push_entry),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dl_rise) state_d = LOAD;
            LOAD:    if (dl_fall) state_d = DRAIN;
            DRAIN: begin
                if (dl_rise)                        state_d = LOAD;
                else if (fifo_empty && !mem_req_q)  state_d = DONE;
            end
            DONE:    state_d = dl_rise ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign start     = (state_d == LOAD) && (state_q != LOAD);
    assign rom_reset = ((state_q == LOAD) || (state_q == DRAIN)) && (idx_q == ROM_INDEX);
    assign dn_busy   = (state_q == LOAD) || (state_q == DRAIN) || mem_req_q;
    assign dbg_state = state_q;

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = iss_q.addr;
    assign bus.mem_data = iss_q.data;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dl_q      <= 1'b0;
            idx_q     <= ROM_INDEX;
            mem_req_q <= 1'b0;
            iss_q     <= '0;
            cas_len   <= '0;
            cas_ready <= 1'b0;
            overflow  <= 1'b0;
`ifdef HT_DN_CHECKSUM_EN
            dn_sum    <= '0;
`endif
        end else begin
            state_q <= state_d;
            dl_q    <= bus.ioctl_download;

            // start and push never coincide: pushes need state_q == LOAD.
            if (start) begin
                idx_q    <= bus.ioctl_index;
                overflow <= 1'b0;
                if (bus.ioctl_index != ROM_INDEX) begin
                    cas_len   <= '0;
                    cas_ready <= 1'b0;
                end
`ifdef HT_DN_CHECKSUM_EN
                dn_sum <= '0;
`endif
            end

            if (push_req && fifo_full && !pop) overflow <= 1'b1;

            if (push_ok && (idx_q != ROM_INDEX) && (new_len > cas_len)) cas_len <= new_len;

`ifdef HT_DN_CHECKSUM_EN
            if (push_ok) dn_sum <= dn_sum + bus.ioctl_data;
`endif

            if ((state_q == DONE) && (state_d == IDLE) && (idx_q != ROM_INDEX)) cas_ready <= 1'b1;

            // Issue register: load only when idle, so writes are at most one per two cycles.
            if (pop) begin
                iss_q     <= fifo_rdata;
                mem_req_q <= 1'b1;
            end else if (mem_req_q && bus.mem_ack) begin
                mem_req_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ht_dn_bridge.sv
// tb_ht_dn_bridge: self-checking bench for ht_dn_bridge.
// Build with HT_DN_CHECKSUM_EN defined to also cover dn_sum.
`timescale 1ns/1ps
module tb_ht_dn_bridge;
    import ht_dn_pkg::*;

    localparam int W          = DN_ADDR_W + 8;
    localparam int FIFO_DEPTH = 8;
    localparam logic [DN_ADDR_W-1:0] CAS = 25'h0010000;

    // ---------------- clock / reset ----------------
    logic      clk_sys = 1'b0;
    logic      reset;
    logic      dn_busy, rom_reset, cas_ready, overflow;
    logic [14:0] cas_len;
    dn_state_t dbg_state;
`ifdef HT_DN_CHECKSUM_EN
    logic [7:0] dn_sum;
`endif

    always #5 clk_sys = ~clk_sys;

    ht_dn_bridge_if #(.ADDR_W(DN_ADDR_W)) bus ();

    ht_dn_bridge #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (DN_ADDR_W),
        .CAS_BASE   (CAS)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .bus       (bus),
        .dn_busy   (dn_busy),
        .rom_reset (rom_reset),
        .cas_len   (cas_len),
        .cas_ready (cas_ready),
        .overflow  (overflow),
        .dbg_state (dbg_state)
`ifdef HT_DN_CHECKSUM_EN
        ,
        .dn_sum    (dn_sum)
`endif
    );

    // ---------------- scoreboard / model state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    logic [DN_ADDR_W-1:0] cur_base;
    logic [7:0]  cur_idx;
    logic [14:0] exp_cas_len;
    logic        exp_cas_ready;
    logic        exp_ovf;
    logic [7:0]  exp_sum;

    int ack_delay = 0;
    bit ack_hold  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side responder: acks each request after ack_delay cycles and logs the write.
    initial begin : responder
        int cnt;
        cnt = 0;
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !ack_hold && !reset) begin
                if (cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    got_q.push_back({bus.mem_addr, bus.mem_data});
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys); #1;
        end
    endtask

    task automatic dl_start(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        step();
        cur_idx  = idx;
        cur_base = (idx == 8'd0) ? '0 : CAS;
        exp_ovf  = 1'b0;
        exp_sum  = '0;
        if (idx != 8'd0) begin
            exp_cas_len   = '0;
            exp_cas_ready = 1'b0;
        end
    endtask

    task automatic wr_byte(input logic [13:0] a, input logic [7:0] d, input bit accepted = 1'b1);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_data = d;
        step();
        bus.ioctl_wr = 1'b0;
        if (accepted) begin
            exp_q.push_back({cur_base + DN_ADDR_W'(a), d});
            exp_sum = exp_sum + d;
            if (cur_idx != 8'd0 && (15'(a) + 15'd1) > exp_cas_len) exp_cas_len = 15'(a) + 15'd1;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic dl_end();
        bus.ioctl_download = 1'b0;
        step();
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (dbg_state == IDLE && !dn_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle_reached"}, ok, 1'b1);
        if (cur_idx != 8'd0) exp_cas_ready = 1'b1;
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_write_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [W-1:0] g;
            logic [W-1:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cas_len"}, cas_len, exp_cas_len);
        check({tag, "_cas_ready"}, cas_ready, exp_cas_ready);
        check({tag, "_overflow"}, overflow, exp_ovf);
`ifdef HT_DN_CHECKSUM_EN
        check({tag, "_dn_sum"}, dn_sum, exp_sum);
`endif
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : stim
        logic [7:0]  d0;
        logic [7:0]  idx;
        logic [13:0] base_a;
        int          n;

        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_data     = '0;
        bus.ioctl_index    = '0;
        cur_idx = '0; cur_base = '0;
        exp_cas_len = '0; exp_cas_ready = 1'b0; exp_ovf = 1'b0; exp_sum = '0;
        step(3);

        // Reset state
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_dn_busy", dn_busy, 1'b0);
        check("rst_rom_reset", rom_reset, 1'b0);
        check("rst_state", dbg_state, IDLE);
        check_status("rst");
        @(negedge clk_sys);
        reset = 1'b0;
        step(2);

        // ROM load: two bytes, ack one cycle after each request
        ack_delay = 1;
        dl_start(8'd0);
        check("rom_rom_reset_load", rom_reset, 1'b1);
        check("rom_busy_load", dn_busy, 1'b1);
        wr_byte(14'd0, 8'h11);
        wr_byte(14'd1, 8'h22);
        dl_end();
        check("rom_rom_reset_drain", rom_reset, 1'b1);
        wait_idle("rom");
        check("rom_rom_reset_after", rom_reset, 1'b0);
        compare_writes("rom");
        check_status("rom");

        // Cassette load: index changes mid-download must be ignored
        dl_start(8'd1);
        bus.ioctl_index = 8'd0;
        check("cas_rom_reset", rom_reset, 1'b0);
        for (int i = 0; i < 3; i++) wr_byte(14'(i), 8'($urandom_range(0, 255)));
        check("cas_ready_during", cas_ready, 1'b0);
        dl_end();
        wait_idle("cas");
        compare_writes("cas");
        check_status("cas");

        // Strobes outside LOAD are ignored
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = 14'h55;
        step();
        bus.ioctl_wr = 1'b0;
        step(5);
        check("idle_wr_writes", got_q.size(), 0);
        check("idle_wr_busy", dn_busy, 1'b0);

        // Latency: strobe in cycle N gives mem_req in cycle N+2
        ack_delay = 0;
        dl_start(8'd0);
        step(2);
        wr_byte(14'h123, 8'h5A);
        check("lat_n1", bus.mem_req, 1'b0);
        step();
        check("lat_n2", bus.mem_req, 1'b1);
        dl_end();
        wait_idle("lat");
        compare_writes("lat");
        check_status("lat");

        // Back-pressure: ack withheld, 10 strobes, 9 fit
        ack_hold = 1'b1;
        dl_start(8'd0);
        d0 = 8'($urandom_range(0, 255));
        for (int i = 0; i < 10; i++)
            wr_byte(14'(16'h20 + i), (i == 0) ? d0 : 8'($urandom_range(0, 255)), i < 9);
        check("bp_overflow", overflow, 1'b1);
        check("bp_req_held", bus.mem_req, 1'b1);
        step(5);
        check("bp_req_still", bus.mem_req, 1'b1);
        check("bp_addr_stable", bus.mem_addr, 25'h20);
        check("bp_data_stable", bus.mem_data, d0);
        check("bp_no_writes", got_q.size(), 0);
        dl_end();
        ack_hold  = 1'b0;
        ack_delay = 1;
        wait_idle("bp");
        compare_writes("bp");
        check_status("bp");

        // Boundary: top cassette offset gives cas_len 0x4000
        dl_start(8'd2);
        wr_byte(14'h3FFF, 8'hA5);
        wr_byte(14'h0005, 8'h3C);
        dl_end();
        wait_idle("top");
        compare_writes("top");
        check_status("top");

        // Randomized downloads against the model
        for (int t = 0; t < 6; t++) begin
            idx = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            ack_delay = $urandom_range(0, 3);
            n = $urandom_range(1, 8);
            base_a = 14'($urandom_range(0, 16000));
            dl_start(idx);
            bus.ioctl_index = 8'($urandom_range(0, 255));
            for (int i = 0; i < n; i++) begin
                step($urandom_range(0, 2));
                wr_byte(base_a + 14'($urandom_range(0, 300)), 8'($urandom_range(0, 255)));
            end
            dl_end();
            wait_idle("rnd");
            compare_writes("rnd");
            check_status("rnd");
        end

`ifdef HT_DN_CHECKSUM_EN
        // Checksum wraps modulo 256
        dl_start(8'd0);
        wr_byte(14'd0, 8'hF0);
        wr_byte(14'd1, 8'h20);
        dl_end();
        wait_idle("sum");
        check("sum_value", dn_sum, 8'h10);
        compare_writes("sum");
`endif

        // Async reset with a pending request and three queued entries
        ack_hold  = 1'b1;
        ack_delay = 0;
        dl_start(8'd5);
        for (int i = 0; i < 4; i++) wr_byte(14'(i), 8'($urandom_range(0, 255)));
        check("ar_req_before", bus.mem_req, 1'b1);
        check("ar_cas_len_before", cas_len, exp_cas_len);
        @(negedge clk_sys);
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        #1;
        check("ar_req_async", bus.mem_req, 1'b0);
        check("ar_busy", dn_busy, 1'b0);
        check("ar_state", dbg_state, IDLE);
        exp_cas_len = '0; exp_cas_ready = 1'b0; exp_ovf = 1'b0; exp_sum = '0;
        check_status("ar");
        step(2);
        reset    = 1'b0;
        ack_hold = 1'b0;
        exp_q.delete();
        got_q.delete();
        step(20);
        check("ar_no_writes", got_q.size(), 0);
        check("ar_req_after", bus.mem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ht_dn_bridge.md
Name: ht_dn_bridge

Overview:
- Sits between the HPS ioctl download port and the ht1080z core's memory-write path.
- Latches the download index at start and maps it to a base address: ROM at 0x0000000, cassette image at 0x0010000.
- Buffers incoming bytes in a small address+data FIFO and issues req/ack writes to the core's SDRAM write port.
- Also generates the ROM-load CPU reset and reports the loaded cassette length.

Parameters:
- FIFO_DEPTH, 8: entries in the address+data FIFO; power of two, minimum 2.
- ADDR_W, 25: width of the memory address output.
- CAS_BASE, 25'h0010000: base address for any non-zero ioctl_index.

Ports:
- clk_sys  in  1  system/download clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ioctl_download  in  1  download in progress (level).
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  14  byte offset within the file.
- ioctl_data  in  8  byte value.
- ioctl_index  in  8  file type; 0 = ROM, anything else = cassette.
- mem_req  out  1  write request; held until acked.
- mem_addr  out  ADDR_W  write address; stable while mem_req=1.
- mem_data  out  8  write data; stable while mem_req=1.
- mem_ack  in  1  one-cycle accept from the memory side.
- dn_busy  out  1  download active, or FIFO/request not yet drained.
- rom_reset  out  1  CPU reset request during ROM load.
- cas_len  out  15  highest cassette offset written + 1.
- cas_ready  out  1  cassette image fully drained to memory.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; latched index = 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE -> LOAD on the rising edge of ioctl_download.
  - On entry to LOAD: latch ioctl_index; clear overflow. If the index is non-zero, also clear cas_len and cas_ready.
  - LOAD -> DRAIN on the falling edge of ioctl_download.
  - DRAIN -> DONE when the FIFO is empty and no request is outstanding.
  - DONE -> IDLE after one cycle. On that cycle, cas_ready is set to 1 if the latched index is non-zero.
  - A rising edge of ioctl_download seen in DRAIN or DONE goes to LOAD. Entries already queued are still written at their stored addresses, because each entry carries its own address.
- Address mapping:
  - Stored address = ioctl_addr zero-extended to ADDR_W, plus (latched index==0 ? 0 : CAS_BASE).
  - ioctl_index changing mid-download is ignored.
- FIFO write:
  - Pushes on ioctl_wr only while in LOAD.
  - ioctl_wr when the FIFO is full: the byte is dropped and overflow is set to 1. overflow stays 1 until the next download start.
  - ioctl_wr outside LOAD is ignored.
- Issue stage:
  - When mem_req=0 and the FIFO is non-empty, pop one entry; mem_req=1 on the next cycle.
  - Latency: a byte with ioctl_wr in cycle N onto an idle, empty FIFO shows mem_req=1 in cycle N+2.
  - On mem_ack, mem_req drops the following cycle. The next request comes no earlier than 1 cycle after the ack (maximum 1 write per 2 cycles).
  - mem_ack while mem_req=0 is ignored.
  - A push and a pop in the same cycle are both performed; a full FIFO with a simultaneous pop accepts the push.
- cas_len: on each cassette push, cas_len <= max(cas_len, ioctl_addr+1). 15-bit result; 14'h3FFF gives 0x4000.
- rom_reset: 1 from LOAD entry with index 0 until DONE; 0 otherwise.
- dn_busy: 1 in LOAD and DRAIN, and whenever mem_req=1.
- Reset mid-operation:
  - FIFO is flushed; the pending request is abandoned and mem_req drops immediately (asynchronous).
  - cas_ready = 0.

Optional Feature:
- Macro: HT_DN_CHECKSUM_EN.
- Defined:
  - Adds output dn_sum (8 bits): the modulo-256 sum of every byte accepted into the FIFO (dropped bytes excluded).
  - Cleared on download start; frozen in DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ht_dn_pkg holds:
  - state enum dn_state_t (IDLE, LOAD, DRAIN, DONE);
  - localparams ROM_INDEX=8'd0 and the default CAS_BASE;
  - the packed struct dn_entry_t {addr[ADDR_W-1:0], data[7:0]}.
- One sub-module, ht_dn_fifo: synchronous FIFO with async reset, push/pop/full/empty, with simultaneous push+pop when full permitted.

Test Plan:
- ROM load, index 0, bytes 0x11,0x22 at addresses 0 and 1, mem_ack 1 cycle after each req:
  - writes go to 0x0000000 and 0x0000001;
  - rom_reset is high from the download start to DONE;
  - cas_ready stays 0.
- Cassette load, index 1, 3 bytes at addresses 0..2:
  - mem_addr = 0x0010000..0x0010002;
  - cas_len=3, and cas_ready=1 after the drain.
- Back-pressure: mem_ack withheld, 10 ioctl_wr with FIFO_DEPTH=8:
  - overflow=1 and mem_req stays held;
  - after acks resume, exactly the first 9 bytes are written (8 queued + 1 in the issue register) and the rest are dropped.
- Latency: a single ioctl_wr at cycle N into an idle bridge gives mem_req rising at N+2.
- Async reset asserted while mem_req=1 and the FIFO holds 3 entries:
  - mem_req=0 immediately, and no further writes after release;
  - cas_len and cas_ready are 0.
- With HT_DN_CHECKSUM_EN, bytes 0xF0,0x20 give dn_sum=0x10.
